set_assoc_cache: RTL and testbench

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

---
 rtl/set_assoc_cache.sv | 172 +++++++++++++++++
 tb/tb_set_assoc_cache.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache.sv
// 2-way set-associative, write-through / no-write-allocate cache with LRU replacement,
// blocking CPU interface, single-line fill port and saturating hit/miss counters.
module set_assoc_cache #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 32,
    parameter int SETS   = 64,
    parameter int WORDS  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_req,
    input  logic                    wr_req,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    flush,
    output logic                    ready,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    mem_rd_req,
    output logic                    mem_wr_req,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wr_data,
    input  logic                    mem_ready,
    input  logic [WORDS*DATA_W-1:0] mem_rd_data,
    output logic [CNT_W-1:0]        hit_cnt,
    output logic [CNT_W-1:0]        miss_cnt
);
    localparam int WS_W   = $clog2(WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int IDX_LO = 2 + WS_W;
    localparam int TAG_LO = IDX_LO + IDX_W;
    localparam int TAG_W  = ADDR_W - TAG_LO;

    typedef enum logic [1:0] {IDLE, FILL, RESP, WRITE} state_e;

    state_e state_q, state_d;

    logic [1:0][SETS-1:0] valid_q;
    logic [SETS-1:0]      lru_q;
    logic [TAG_W-1:0]     tag_q  [2][SETS];
    logic [DATA_W-1:0]    data_q [2][SETS][WORDS];
    logic [CNT_W-1:0]     hit_cnt_q, miss_cnt_q;
    logic                 fill_way_q, fill_way_d;
    logic                 flush_pend_q, flush_pend_d;

    logic [WS_W-1:0]  ws;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit0, hit1, hit, hit_way, victim, rd_way;
    logic             fill_we, wr_we, lru_we, lru_val;
    logic             hit_inc, miss_inc, do_flush;
    logic             unused_ok;

    assign ws        = addr[2 +: WS_W];
    assign idx       = addr[IDX_LO +: IDX_W];
    assign tag       = addr[ADDR_W-1:TAG_LO];
    assign unused_ok = ^addr[1:0];

    assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit     = hit0 || hit1;
    assign hit_way = hit1;
    assign victim  = !valid_q[0][idx] ? 1'b0 :
                     !valid_q[1][idx] ? 1'b1 : lru_q[idx];

    always_comb begin
        state_d      = state_q;
        fill_way_d   = fill_way_q;
        flush_pend_d = flush_pend_q | flush;
        ready        = 1'b0;
        mem_rd_req   = 1'b0;
        mem_wr_req   = 1'b0;
        rd_way       = hit_way;
        fill_we      = 1'b0;
        wr_we        = 1'b0;
        lru_we       = 1'b0;
        lru_val      = ~hit_way;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        do_flush     = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    state_d = WRITE;
                end else if (rd_req) begin
                    if (hit) begin
                        ready   = 1'b1;
                        lru_we  = 1'b1;
                        hit_inc = 1'b1;
                    end else begin
                        state_d  = FILL;
                        miss_inc = 1'b1;
                    end
                end else if (flush_pend_d) begin
                    // Flush only takes effect on a quiet IDLE cycle; otherwise it stays pending.
                    do_flush     = 1'b1;
                    flush_pend_d = 1'b0;
                end
            end
            FILL: begin
                mem_rd_req = 1'b1;
                if (mem_ready) begin
                    fill_we    = 1'b1;
                    lru_we     = 1'b1;
                    lru_val    = ~victim;
                    fill_way_d = victim;
                    state_d    = RESP;
                end
            end
            RESP: begin
                ready   = 1'b1;
                rd_way  = fill_way_q;
                state_d = IDLE;
            end
            WRITE: begin
                mem_wr_req = 1'b1;
                if (mem_ready) begin
                    ready   = 1'b1;
                    state_d = IDLE;
                    if (hit) begin
                        wr_we  = 1'b1;
                        lru_we = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr    = (state_q == FILL) ? {addr[ADDR_W-1:IDX_LO], {IDX_LO{1'b0}}}
                                           : {addr[ADDR_W-1:2], 2'b00};
    assign mem_wr_data = wr_data;
    assign rd_data     = data_q[rd_way][idx][ws];
    assign hit_cnt     = hit_cnt_q;
    assign miss_cnt    = miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            lru_q        <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            fill_way_q   <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_way_q   <= fill_way_d;
            flush_pend_q <= flush_pend_d;
            if (do_flush) begin
                valid_q <= '0;
                lru_q   <= '0;
            end else begin
                if (fill_we) valid_q[victim][idx] <= 1'b1;
                if (lru_we)  lru_q[idx]           <= lru_val;
            end
            if (hit_inc && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 1'b1;
            if (miss_inc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    // Tag/data storage is never reset; validity alone decides whether contents are used.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[victim][idx] <= tag;
            for (int w = 0; w < WORDS; w++)
                data_q[victim][idx][w] <= mem_rd_data[w*DATA_W +: DATA_W];
        end
        if (wr_we) data_q[hit_way][idx][ws] <= wr_data;
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: fills, hits, LRU replacement, write-through,
// flush (immediate and deferred), counter saturation and asynchronous reset mid-fill.
module tb_set_assoc_cache;
    logic        clk, rst_n, rd_req, wr_req, flush, ready;
    logic        mem_rd_req, mem_wr_req, mem_ready;
    logic [18:0] addr, mem_addr;
    logic [31:0] wr_data, rd_data, mem_wr_data;
    logic [63:0] mem_rd_data;
    logic [15:0] hit_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;
    int exp_hit = 0;
    int exp_miss = 0;

    set_assoc_cache dut (
        .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
        .wr_data(wr_data), .flush(flush), .ready(ready), .rd_data(rd_data),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_ready(mem_ready), .mem_rd_data(mem_rd_data),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ".hit_cnt"}, 64'(hit_cnt), 64'(exp_hit));
        chk({tag, ".miss_cnt"}, 64'(miss_cnt), 64'(exp_miss));
    endtask

    task automatic read_miss(input logic [18:0] a, input logic [63:0] line, input int lat,
                             input logic [31:0] exp_word);
        tick();
        rd_req = 1'b1; addr = a; mem_rd_data = line;
        #4;
        chk("miss.no_ready", 64'(ready), 64'd0);
        for (int i = 1; i <= lat; i++) begin
            tick();
            mem_ready = (i == lat);
            #4;
            chk("fill.mem_rd_req", 64'(mem_rd_req), 64'd1);
            chk("fill.mem_wr_req", 64'(mem_wr_req), 64'd0);
            chk("fill.mem_addr", 64'(mem_addr), 64'(a & 19'h7FFF8));
            chk("fill.ready", 64'(ready), 64'd0);
        end
        tick();
        mem_ready = 1'b0;
        #4;
        chk("resp.ready", 64'(ready), 64'd1);
        chk("resp.rd_data", 64'(rd_data), 64'(exp_word));
        chk("resp.mem_rd_req", 64'(mem_rd_req), 64'd0);
        tick();
        rd_req = 1'b0;
        exp_miss++;
        chk_cnt("read_miss");
    endtask

    task automatic read_hit(input logic [18:0] a, input logic [31:0] exp_word);
        tick();
        rd_req = 1'b1; addr = a;
        #4;
        chk("hit.ready", 64'(ready), 64'd1);
        chk("hit.rd_data", 64'(rd_data), 64'(exp_word));
        chk("hit.mem_rd_req", 64'(mem_rd_req), 64'd0);
        tick();
        rd_req = 1'b0;
        exp_hit++;
        chk_cnt("read_hit");
    endtask

    task automatic write_word(input logic [18:0] a, input logic [31:0] d, input int lat);
        tick();
        wr_req = 1'b1; addr = a; wr_data = d;
        #4;
        chk("wr.idle_ready", 64'(ready), 64'd0);
        for (int i = 1; i <= lat; i++) begin
            tick();
            mem_ready = (i == lat);
            #4;
            chk("wr.mem_wr_req", 64'(mem_wr_req), 64'd1);
            chk("wr.mem_rd_req", 64'(mem_rd_req), 64'd0);
            chk("wr.mem_addr", 64'(mem_addr), 64'(a & 19'h7FFFC));
            chk("wr.mem_wr_data", 64'(mem_wr_data), 64'(d));
            chk("wr.ready", 64'(ready), 64'(i == lat));
        end
        tick();
        wr_req = 1'b0; mem_ready = 1'b0;
        #4;
        chk("wr.after_mem_wr_req", 64'(mem_wr_req), 64'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        addr = '0; wr_data = '0; mem_rd_data = '0;
        #3;
        chk("rst.ready", 64'(ready), 64'd0);
        chk("rst.mem_rd_req", 64'(mem_rd_req), 64'd0);
        chk("rst.mem_wr_req", 64'(mem_wr_req), 64'd0);
        chk_cnt("rst");
        tick();
        rst_n = 1'b1;

        // Cold miss with 3-cycle memory latency, then hit on the other word of the line.
        read_miss(19'h00040, {32'h22222222, 32'h11111111}, 3, 32'h11111111);
        read_hit(19'h00044, 32'h22222222);

        // Set 8: A=0x00040 (way0), B=0x00240, C=0x00440. A recently used, so C evicts B.
        read_miss(19'h00240, {32'hB1B1B1B1, 32'hB0B0B0B0}, 1, 32'hB0B0B0B0);
        read_hit(19'h00040, 32'h11111111);
        read_miss(19'h00444, {32'hC1C1C1C1, 32'hC0C0C0C0}, 2, 32'hC1C1C1C1);
        read_hit(19'h00040, 32'h11111111);
        read_miss(19'h00244, {32'hB1B1B1B1, 32'hB0B0B0B0}, 1, 32'hB1B1B1B1);

        // Write-through hit updates the cached word; neighbour word untouched.
        write_word(19'h00040, 32'hDEADBEEF, 2);
        read_hit(19'h00040, 32'hDEADBEEF);
        read_hit(19'h00044, 32'h22222222);
        // Write miss does not allocate.
        write_word(19'h00840, 32'h12345678, 1);
        read_miss(19'h00840, {32'hD1D1D1D1, 32'hD0D0D0D0}, 1, 32'hD0D0D0D0);

        // Immediate flush on a quiet IDLE cycle.
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        read_miss(19'h00040, {32'h44444444, 32'h33333333}, 1, 32'h33333333);

        // Flush raised together with a hit: the hit completes, the flush follows.
        tick();
        rd_req = 1'b1; addr = 19'h00040; flush = 1'b1;
        #4;
        chk("flushreq.ready", 64'(ready), 64'd1);
        chk("flushreq.rd_data", 64'(rd_data), 64'h33333333);
        exp_hit++;
        tick();
        rd_req = 1'b0; flush = 1'b0;
        tick();
        read_miss(19'h00040, {32'h66666666, 32'h55555555}, 2, 32'h55555555);

        // Hold a hit until the counter saturates, then keep hitting.
        tick();
        rd_req = 1'b1; addr = 19'h00044;
        n = 0;
        while (hit_cnt != 16'hFFFF && n < 70000) begin
            tick();
            n++;
        end
        chk("sat.reached", 64'(hit_cnt), 64'hFFFF);
        tick();
        tick();
        #4;
        chk("sat.hold", 64'(hit_cnt), 64'hFFFF);
        chk("sat.ready", 64'(ready), 64'd1);
        chk("sat.rd_data", 64'(rd_data), 64'h66666666);
        tick();
        rd_req = 1'b0;
        exp_hit = 16'hFFFF;
        chk_cnt("sat");

        // Asynchronous reset in the middle of a fill.
        tick();
        rd_req = 1'b1; addr = 19'h01040; mem_rd_data = {32'h88888888, 32'h77777777};
        tick();
        #4;
        chk("rstfill.mem_rd_req_before", 64'(mem_rd_req), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstfill.mem_rd_req_async", 64'(mem_rd_req), 64'd0);
        chk("rstfill.hit_cnt", 64'(hit_cnt), 64'd0);
        chk("rstfill.miss_cnt", 64'(miss_cnt), 64'd0);
        rd_req = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_hit = 0;
        exp_miss = 0;
        read_miss(19'h01040, {32'h88888888, 32'h77777777}, 1, 32'h77777777);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
